// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII control characters and the line-echo FSM state encoding.
package uart_pkg;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    SEND    = 2'd1,
    SEND_CR = 2'd2,
    SEND_LF = 2'd3
  } echo_state_e;

endpackage

// File: rtl/line_mem.sv
// Line buffer: DEPTH x 8, one synchronous write port, one asynchronous read port.
module line_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_echo.sv
// Buffers one received line and echoes it back terminated by CR,LF.
// Optional feature macro: UART_LINE_ECHO_BACKSPACE_EN (BS deletes the last buffered byte).
module uart_line_echo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

`ifdef UART_LINE_ECHO_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  echo_state_e   state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] rd_idx, rd_idx_nxt;
  logic          tx_valid_nxt, busy_nxt, overflow_nxt;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          is_cr, is_lf, is_bs, full, last, xfer;

  assign is_cr = (rx_data == CR);
  assign is_lf = (rx_data == LF);
  assign is_bs = (rx_data == BS);
  assign full  = (count == CW'(DEPTH));
  assign last  = ({1'b0, rd_idx} == (count - CW'(1)));
  assign xfer  = tx_valid && tx_ready;

  line_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (count[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  // State, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      count    <= '0;
      rd_idx   <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      rd_idx   <= rd_idx_nxt;
      tx_valid <= tx_valid_nxt;
      busy     <= busy_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Next-state, buffer write and drop detection
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    rd_idx_nxt   = rd_idx;
    mem_we       = 1'b0;
    overflow_nxt = 1'b0;

    unique case (state)
      FILL: begin
        if (rx_valid) begin
          if (is_cr) begin
            state_nxt = (count != '0) ? SEND : SEND_CR;
          end else if (!is_lf) begin
            if (BS_EN && is_bs) begin
              if (count != '0) count_nxt = count - CW'(1);
            end else if (full) begin
              overflow_nxt = 1'b1;
            end else begin
              mem_we    = 1'b1;
              count_nxt = count + CW'(1);
            end
          end
        end
      end
      SEND: begin
        overflow_nxt = rx_valid;
        if (xfer) begin
          if (last) state_nxt  = SEND_CR;
          else      rd_idx_nxt = rd_idx + AW'(1);
        end
      end
      SEND_CR: begin
        overflow_nxt = rx_valid;
        if (xfer) state_nxt = SEND_LF;
      end
      SEND_LF: begin
        overflow_nxt = rx_valid;
        if (xfer) begin
          state_nxt  = FILL;
          count_nxt  = '0;
          rd_idx_nxt = '0;
        end
      end
      default: state_nxt = FILL;
    endcase

    tx_valid_nxt = (state_nxt != FILL);
    busy_nxt     = (state_nxt != FILL);
  end

  // Byte offered to the transmitter, decoded from the registered state
  always_comb begin
    tx_data = 8'h00;
    unique case (state)
      SEND:    tx_data = mem_rdata;
      SEND_CR: tx_data = CR;
      SEND_LF: tx_data = LF;
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_line_echo.sv
// Directed scoreboard bench for uart_line_echo (DEPTH=8).
module tb_uart_line_echo;

  localparam int unsigned DEPTH = 8;

`ifdef UART_LINE_ECHO_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  uart_line_echo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overflow (overflow)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         ovf_seen = 0;
  int         exp_ovf  = 0;
  logic [7:0] exp_q[$];
  bit         hold_pending = 1'b0;
  logic [7:0] held_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    if (hold_pending) check("tx_hold_stable", 32'(tx_data), 32'(held_data));
    if (tx_valid === 1'b1 && tx_ready && !rst) begin
      if (exp_q.size() == 0) check("tx_extra_byte", 32'(tx_data), 32'h100);
      else                   check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (overflow === 1'b1) ovf_seen++;
    hold_pending = (tx_valid === 1'b1) && !tx_ready && !rst;
    held_data    = tx_data;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Feed a line plus CR; the reference model predicts echo bytes and drops
  task automatic send_line(input string s);
    logic [7:0] c;
    logic [7:0] line_buf[$];
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c != 8'h0A) begin
        if (BS_EN && c == 8'h08) begin
          if (line_buf.size() > 0) void'(line_buf.pop_back());
        end else if (line_buf.size() < DEPTH) begin
          line_buf.push_back(c);
        end else begin
          exp_ovf++;
        end
      end
      rx_byte(c);
    end
    foreach (line_buf[k]) exp_q.push_back(line_buf[k]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    rx_byte(8'h0D);
    check("tx_valid_after_cr", 32'(tx_valid), 32'd1);
    check("busy_after_cr", 32'(busy), 32'd1);
    check("first_tx_byte", 32'(tx_data),
          (line_buf.size() > 0) ? 32'(line_buf[0]) : 32'h0D);
  endtask

  task automatic drain(input string tag);
    int budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_tx_valid_low"}, 32'(tx_valid), 32'd0);
    check({tag, "_overflow_count"}, 32'(ovf_seen), 32'(exp_ovf));
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    tick();
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    rst = 1'b0;
    tick();

    send_line("AB");
    drain("ab");

    send_line("");
    drain("cr_only");

    rx_byte(8'h0A);
    repeat (3) tick();
    check("lf_alone_tx_valid", 32'(tx_valid), 32'd0);
    check("lf_alone_overflow", 32'(ovf_seen), 32'(exp_ovf));

    send_line("ABCDEFGHIJ");
    drain("overfill");

    // Backpressure: hold the first byte, drop a byte arriving while busy
    tx_ready = 1'b0;
    send_line("XY");
    repeat (4) tick();
    rx_byte(8'h5A);
    exp_ovf++;
    repeat (5) tick();
    check("stall_tx_valid", 32'(tx_valid), 32'd1);
    check("stall_tx_data", 32'(tx_data), 32'h58);
    tx_ready = 1'b1;
    drain("stall");

    send_line("ABC\010D");
    drain("backspace");

    // Reset after the first transfer aborts the line
    tx_ready = 1'b0;
    rx_byte(8'h41);
    rx_byte(8'h42);
    rx_byte(8'h43);
    rx_byte(8'h0D);
    check("abort_first_byte", 32'(tx_data), 32'h41);
    exp_q.push_back(8'h41);
    tx_ready = 1'b1;
    tick();
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'h00);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    tick();
    check("abort_idle_tx_valid", 32'(tx_valid), 32'd0);
    send_line("Q");
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_line_echo.md
UART_LINE_ECHO -- requirements
Module: uart_line_echo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the line buffer capacity in bytes (power of two, 4..256).
REQ-002 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port rx_data, input, 8, the byte from the UART receiver.
REQ-005 The block SHALL have port rx_valid, input, 1, a one-cycle strobe per received byte.
REQ-006 The block SHALL have port tx_data, output, 8, the byte offered to the UART transmitter.
REQ-007 The block SHALL have port tx_valid, output, 1, meaning tx_data is valid.
REQ-008 The block SHALL have port tx_ready, input, 1, meaning the transmitter can accept a byte.
REQ-009 The block SHALL have port busy, output, 1, high in any state other than FILL.
REQ-010 The block SHALL have port overflow, output, 1, a one-cycle pulse for each dropped input byte.

Function
REQ-011 The state machine SHALL have states FILL, SEND, SEND_CR and SEND_LF.
REQ-012 In FILL, an rx_valid byte other than CR (0x0D) or LF (0x0A) SHALL be written at index count, and count SHALL increment in the same cycle.
REQ-013 In FILL, LF SHALL be ignored, with no store and no overflow pulse.
REQ-014 In FILL, CR SHALL move the FSM to SEND if count>0, otherwise to SEND_CR; CR itself is never stored.
REQ-015 When count==DEPTH, each further non-CR, non-LF byte SHALL be dropped and overflow SHALL pulse for one cycle; CR still terminates the line.
REQ-016 tx_valid SHALL assert in the cycle after CR is accepted, carrying buffer[0] in SEND or 0x0D in SEND_CR.
REQ-017 A byte SHALL transfer only in a cycle where tx_valid and tx_ready are both high.
REQ-018 tx_data SHALL stay stable while tx_valid is high and no transfer has occurred.
REQ-019 In SEND, each transfer SHALL advance rd_idx, and the transfer of byte count-1 SHALL move the FSM to SEND_CR.
REQ-020 In SEND_CR, tx_data SHALL be 0x0D, and a transfer SHALL move the FSM to SEND_LF.
REQ-021 In SEND_LF, tx_data SHALL be 0x0A, and a transfer SHALL clear count and rd_idx and move the FSM to FILL.
REQ-022 tx_valid SHALL be high in every state except FILL, so there are no idle cycles between line bytes when tx_ready stays high.
REQ-023 Any rx_valid byte arriving while busy is high SHALL be dropped with an overflow pulse.
REQ-024 count SHALL be log2(DEPTH)+1 bits wide so it can hold DEPTH without wrap-around.
REQ-025 tx_data SHALL be 0x00 in FILL.

Reset
REQ-026 On rst, in the next cycle: state=FILL, count=0, rd_idx=0, tx_valid=0, tx_data=0x00, busy=0, overflow=0; buffer contents are not cleared.
REQ-027 rst asserted mid-line or mid-send SHALL abort the line immediately with no further tx_valid.
REQ-028 rst SHALL take priority over rx_valid and tx_ready in the same cycle.

Configuration
REQ-029 With macro UART_LINE_ECHO_BACKSPACE_EN defined, BS (0x08) in FILL SHALL decrement count if count>0, be ignored if count==0, and never be stored or raise overflow.
REQ-030 Without UART_LINE_ECHO_BACKSPACE_EN, BS SHALL be stored as an ordinary byte.

Structure
REQ-031 Shared package uart_pkg SHALL hold the ASCII constants CR, LF and BS and the line-echo state encoding.
REQ-032 Storage SHALL be sub-module line_mem: DEPTH x 8, one synchronous write port, one asynchronous read port addressed by rd_idx.

Verification
REQ-033 Send "AB",CR with tx_ready=1 -> tx sequence 0x41,0x42,0x0D,0x0A, first tx_valid one cycle after CR; busy falls after the LF transfer.
REQ-034 Send CR alone -> tx sequence 0x0D,0x0A only; LF input alone -> no tx activity and no overflow.
REQ-035 DEPTH=4: send "ABCDEF",CR -> two overflow pulses (E, F); tx sequence "ABCD",CR,LF.
REQ-036 Send "XY",CR, then hold tx_ready=0 for 10 cycles -> tx_data held at 0x58 with tx_valid=1; a byte 0x5A received meanwhile -> overflow pulse, not echoed.
REQ-037 Assert rst during SEND after the first transfer -> next cycle tx_valid=0, busy=0; a following "Q",CR -> 0x51,0x0D,0x0A.
REQ-038 With UART_LINE_ECHO_BACKSPACE_EN defined: "ABC",BS,"D",CR -> "ABD",CR,LF; without it -> "ABC",0x08,"D",CR,LF.
